btb_datapath: RTL and testbench

- Storage and compare datapath of the 4-way set-associative branch target buffer.
- Holds per-set valid/tag/target for four ways plus a 3-bit tree pseudo-LRU per set.
- Fetch side: combinational lookup of the fetch PC, giving hit and predicted target.
- Writeback side: drives wb_hit, per-way compare results and lru_out to the BTB control block; applies its way write strobes and lru_load on the clock edge.

---
 rtl/btb_datapath_pkg.sv | 21 ++
 rtl/btb_way.sv | 37 +++
 rtl/btb_datapath.sv | 54 +++++
 tb/tb_btb_datapath.sv | 126 ++++++++++++
 4 files changed

// File: rtl/btb_datapath_pkg.sv
// btb_types: shared widths, types and address/PLRU helpers for the BTB datapath.
package btb_types;
   localparam int SET_BITS = 3;
   localparam int ADDR_W = 32;
   localparam int OFS_BITS = 2;
   localparam int TAG_W = ADDR_W - OFS_BITS - SET_BITS;
   localparam int NSETS = 1 << SET_BITS;
   typedef logic [TAG_W-1:0] btb_tag_t;
   typedef logic [SET_BITS-1:0] btb_idx_t;
   typedef logic [2:0] btb_plru_t;
   function automatic btb_idx_t get_idx(input logic [ADDR_W-1:0] pc);
      return pc[OFS_BITS +: SET_BITS];
   endfunction
   function automatic btb_tag_t get_tag(input logic [ADDR_W-1:0] pc);
      return pc[ADDR_W-1:OFS_BITS+SET_BITS];
   endfunction
   // bit0 points away from the touched pair; bit1/bit2 record which way of the pair was touched
   function automatic btb_plru_t plru_next(input btb_plru_t plru, input logic [1:0] way);
      return way[1] ? {way[0], plru[1], 1'b1} : {plru[2], way[0], 1'b0};
   endfunction
endpackage

// File: rtl/btb_way.sv
// btb_way: one way of the BTB -- per-set valid/tag/target with a fetch and a writeback compare port.
module btb_way
   import btb_types::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  btb_idx_t          w_idx,
   input  btb_tag_t          w_tag,
   input  logic [ADDR_W-1:0] w_target,
   input  btb_idx_t          f_idx,
   input  btb_tag_t          f_tag,
   output logic              f_hit,
   output logic [ADDR_W-1:0] f_target,
   input  btb_idx_t          b_idx,
   input  btb_tag_t          b_tag,
   output logic              b_hit
);
   logic [NSETS-1:0] valid;
   btb_tag_t tag [NSETS];
   logic [ADDR_W-1:0] target [NSETS];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid <= '0;
         for (int i = 0; i < NSETS; i++) begin
            tag[i] <= '0;
            target[i] <= '0;
         end
      end else if (we) begin
         valid[w_idx] <= 1'b1;
         tag[w_idx] <= w_tag;
         target[w_idx] <= w_target;
      end
   assign f_hit = valid[f_idx] && (tag[f_idx] == f_tag);
   assign f_target = {ADDR_W{f_hit}} & target[f_idx];
   assign b_hit = valid[b_idx] && (tag[b_idx] == b_tag);
endmodule

// File: rtl/btb_datapath.sv
// btb_datapath: 4-way set-associative BTB storage, fetch/writeback compare and per-set tree PLRU.
module btb_datapath
   import btb_types::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] fetch_pc,
   output logic              pc_hit,
   output logic [ADDR_W-1:0] pc_target,
   input  logic [ADDR_W-1:0] wb_pc,
   input  logic [ADDR_W-1:0] wb_target,
   output logic              wb_hit,
   output logic              wb_comp0_out,
   output logic              wb_comp1_out,
   output logic              wb_comp2_out,
   output logic              wb_comp3_out,
   output logic [2:0]        lru_out,
   input  logic              way0_write,
   input  logic              way1_write,
   input  logic              way2_write,
   input  logic              way3_write,
   input  logic              lru_load
);
   logic [3:0] way_we, f_hit, b_hit;
   logic [ADDR_W-1:0] f_target [4];
   btb_plru_t plru [NSETS];
   btb_idx_t w_idx;
   logic [1:0] lru_way;
   assign way_we = {way3_write, way2_write, way1_write, way0_write};
   assign w_idx = get_idx(wb_pc);
   for (genvar g = 0; g < 4; g++) begin : g_way
      btb_way u_way (
         .clk(clk), .rst_n(rst_n), .we(way_we[g]),
         .w_idx(w_idx), .w_tag(get_tag(wb_pc)), .w_target(wb_target),
         .f_idx(get_idx(fetch_pc)), .f_tag(get_tag(fetch_pc)),
         .f_hit(f_hit[g]), .f_target(f_target[g]),
         .b_idx(w_idx), .b_tag(get_tag(wb_pc)), .b_hit(b_hit[g])
      );
   end
   assign pc_hit = |f_hit;
   assign pc_target = f_target[0] | f_target[1] | f_target[2] | f_target[3];
   assign wb_hit = |b_hit;
   assign {wb_comp3_out, wb_comp2_out, wb_comp1_out, wb_comp0_out} = b_hit;
   assign lru_out = plru[w_idx];
   // with illegal multi-strobe writes the lowest strobed way drives the PLRU update
   assign lru_way = way_we[0] ? 2'd0 : way_we[1] ? 2'd1 : way_we[2] ? 2'd2 : 2'd3;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NSETS; i++) plru[i] <= '0;
      end else if (lru_load && |way_we) begin
         plru[w_idx] <= plru_next(plru[w_idx], lru_way);
      end
   a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(way_we));
endmodule

// File: tb/tb_btb_datapath.sv
// tb_btb_datapath: directed vectors; expectations queued by stimulus, checked by a negedge monitor.
module tb_btb_datapath;
   logic clk = 0, rst_n = 0;
   logic [31:0] fetch_pc = 0, wb_pc = 0, wb_target = 0, pc_target;
   logic pc_hit, wb_hit, c0, c1, c2, c3, lru_load = 0;
   logic [2:0] lru_out;
   logic [3:0] we = 0;
   typedef struct {string name; int sel; logic [31:0] v;} exp_t;
   exp_t q [$];
   int vectors = 0, miscompares = 0;
   always #5 clk = ~clk;
   btb_datapath dut (
      .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pc_hit(pc_hit), .pc_target(pc_target),
      .wb_pc(wb_pc), .wb_target(wb_target), .wb_hit(wb_hit),
      .wb_comp0_out(c0), .wb_comp1_out(c1), .wb_comp2_out(c2), .wb_comp3_out(c3),
      .lru_out(lru_out), .way0_write(we[0]), .way1_write(we[1]), .way2_write(we[2]),
      .way3_write(we[3]), .lru_load(lru_load)
   );
   // sel: 0 pc_hit, 1 pc_target, 2 wb_hit, 3 comps {3..0}, 4 lru_out
   always @(negedge clk)
      while (q.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = q.pop_front();
         act = e.sel == 0 ? {31'd0, pc_hit} : e.sel == 1 ? pc_target : e.sel == 2 ? {31'd0, wb_hit} :
               e.sel == 3 ? {28'd0, c3, c2, c1, c0} : {29'd0, lru_out};
         vectors++;
         if (act !== e.v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.v);
         end
      end
   task automatic expect_v(input string n, input int sel, input logic [31:0] v);
      q.push_back('{n, sel, v});
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic fetch_chk(input string n, input logic [31:0] pc, input logic h, input logic [31:0] t);
      fetch_pc = pc;
      expect_v({n, "_hit"}, 0, {31'd0, h});
      expect_v({n, "_tgt"}, 1, t);
      step();
   endtask
   task automatic wb_chk(input string n, input logic [31:0] pc, input logic h, input logic [3:0] c, input logic [2:0] l);
      wb_pc = pc;
      expect_v({n, "_wbhit"}, 2, {31'd0, h});
      expect_v({n, "_comps"}, 3, {28'd0, c});
      expect_v({n, "_lru"}, 4, {29'd0, l});
      step();
   endtask
   task automatic write(input logic [31:0] pc, input logic [31:0] t, input int way, input logic ll);
      wb_pc = pc;
      wb_target = t;
      we = 4'b1 << way;
      lru_load = ll;
      step();
      we = 0;
      lru_load = 0;
   endtask
   initial begin
      step();
      step();
      rst_n = 1;
      fetch_chk("reset_fetch", 32'h40, 0, 0);
      wb_chk("reset_wb", 32'h40, 0, 4'b0000, 3'b000);
      write(32'h40, 32'h1000, 3, 1);
      fetch_chk("w3_fetch", 32'h40, 1, 32'h1000);
      wb_chk("w3_wb", 32'h40, 1, 4'b1000, 3'b101);
      fetch_chk("ofs_ignored", 32'h43, 1, 32'h1000);
      fetch_chk("set1_miss", 32'h44, 0, 0);
      write(32'h00, 32'hA000, 3, 1);
      write(32'h20, 32'hA020, 1, 1);
      wb_chk("fill_mid", 32'h20, 1, 4'b0010, 3'b110);
      write(32'h40, 32'hA040, 2, 1);
      write(32'h60, 32'hA060, 0, 1);
      wb_chk("fill_done", 32'h60, 1, 4'b0001, 3'b000);
      fetch_chk("fill_00", 32'h00, 1, 32'hA000);
      fetch_chk("fill_20", 32'h20, 1, 32'hA020);
      fetch_chk("fill_40", 32'h40, 1, 32'hA040);
      fetch_chk("fill_60", 32'h60, 1, 32'hA060);
      write(32'h20, 32'hB020, 1, 0);
      fetch_chk("rewrite_20", 32'h20, 1, 32'hB020);
      lru_load = 1;
      step();
      lru_load = 0;
      wb_chk("load_no_strobe", 32'h60, 1, 4'b0001, 3'b000);
      fetch_pc = 32'h80;
      wb_pc = 32'h80;
      wb_target = 32'hB080;
      we = 4'b0100;
      expect_v("same_cycle_pre", 0, 0);
      step();
      we = 0;
      fetch_chk("same_cycle_post", 32'h80, 1, 32'hB080);
      fetch_chk("way2_replaced", 32'h40, 0, 0);
      wb_chk("no_lru_change", 32'h80, 1, 4'b0100, 3'b000);
      fetch_pc = 32'h00;
      wb_pc = 32'h00;
      expect_v("pre_reset_hit", 0, 1);
      step();
      #1 rst_n = 0;
      wb_target = 32'hC000;
      we = 4'b0001;
      lru_load = 1;
      expect_v("rst_hit", 0, 0);
      expect_v("rst_tgt", 1, 0);
      expect_v("rst_wbhit", 2, 0);
      expect_v("rst_comps", 3, 0);
      expect_v("rst_lru", 4, 0);
      step();
      we = 0;
      lru_load = 0;
      rst_n = 1;
      fetch_chk("post_rst_fetch", 32'h00, 0, 0);
      wb_chk("post_rst_wb", 32'h00, 0, 4'b0000, 3'b000);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
